// File: rtl/vec_sweep_checker.sv
// Exhaustive 3-input sweep with settle, sample and truth-table compare.
// Optional FAIL_MASK_EN macro adds a per-vector fail_mask output.
module vec_sweep_checker #(
   parameter int unsigned SETTLE   = 3,
   parameter logic [7:0]  EXPECTED = 8'b0100_0000,
   parameter bit          LOOP     = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       d,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count,
   output logic [2:0] first_fail_idx,
`ifdef FAIL_MASK_EN
   output logic       first_fail_valid,
   output logic [7:0] fail_mask
`else
   output logic       first_fail_valid
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_L = 4'(SETTLE);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] vec;
   logic [3:0] wait_cnt;
   logic       launch;
   logic       sampling;
   logic       miss;
   logic       last;
   logic [3:0] err_nxt;

   assign a = vec[2];
   assign b = vec[1];
   assign c = vec[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start) state_nxt = S_WAIT;
         S_WAIT:   if (wait_cnt == 4'd1) state_nxt = S_SAMPLE;
         S_SAMPLE: state_nxt = (vec == 3'd7) ? S_DONE : S_WAIT;
         S_DONE:   state_nxt = LOOP ? S_WAIT : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // A looping DONE restarts exactly like an accepted start.
   always_comb begin
      launch   = ((state == S_IDLE) && start) ||
                 ((state == S_DONE) && LOOP);
      sampling = (state == S_SAMPLE);
      miss     = sampling && (d != EXPECTED[vec]);
      last     = sampling && (vec == 3'd7);
      err_nxt  = err_count + 4'(miss);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec              <= '0;
         wait_cnt         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
`ifdef FAIL_MASK_EN
         fail_mask        <= '0;
`endif
      end else begin
         done <= last;
         if (launch) begin
            vec              <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            wait_cnt         <= SETTLE_L;
            busy             <= 1'b1;
`ifdef FAIL_MASK_EN
            fail_mask        <= '0;
`endif
         end else begin
            if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (miss) begin
               err_count <= err_nxt;
               if (!first_fail_valid) begin
                  first_fail_idx   <= vec;
                  first_fail_valid <= 1'b1;
               end
`ifdef FAIL_MASK_EN
               fail_mask[vec] <= 1'b1;
`endif
            end
            if (sampling && (vec != 3'd7)) begin
               vec      <= vec + 3'd1;
               wait_cnt <= SETTLE_L;
            end
            // pass lands with the done pulse, vector 7 included.
            if (last) pass <= (err_nxt == 4'd0);
            if (state == S_DONE) busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vec_sweep_checker.sv
// Bench for vec_sweep_checker: truth-table unit models vs a reference model.
// Covers one-shot, ignored start, async reset and LOOP restart.
module tb_vec_sweep_checker;

   localparam logic [7:0] EXP = 8'b0100_0000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       a, b, c, d;
   logic       busy, done, pass;
   logic [3:0] err_count;
   logic [2:0] ffi;
   logic       ffv;
   logic [7:0] unit_tbl;

   logic       start_l;
   logic       a_l, b_l, c_l, d_l;
   logic       busy_l, done_l, pass_l;
   logic [3:0] err_l;
   logic [2:0] ffi_l;
   logic       ffv_l;
   logic [7:0] tbl_l;

`ifdef FAIL_MASK_EN
   logic [7:0] fmask;
   logic [7:0] fmask_l;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   logic [2:0] vsel;
   logic [2:0] vsel_l;
   assign vsel   = {a, b, c};
   assign vsel_l = {a_l, b_l, c_l};
   assign d      = unit_tbl[vsel];
   assign d_l    = tbl_l[vsel_l];

   vec_sweep_checker #(.SETTLE(3), .EXPECTED(EXP), .LOOP(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a), .b(b), .c(c), .d(d),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_fail_idx(ffi),
`ifdef FAIL_MASK_EN
      .first_fail_valid(ffv), .fail_mask(fmask)
`else
      .first_fail_valid(ffv)
`endif
   );

   vec_sweep_checker #(.SETTLE(3), .EXPECTED(EXP), .LOOP(1'b1)) dut_loop (
      .clk(clk), .rst_n(rst_n), .start(start_l),
      .a(a_l), .b(b_l), .c(c_l), .d(d_l),
      .busy(busy_l), .done(done_l), .pass(pass_l),
      .err_count(err_l), .first_fail_idx(ffi_l),
`ifdef FAIL_MASK_EN
      .first_fail_valid(ffv_l), .fail_mask(fmask_l)
`else
      .first_fail_valid(ffv_l)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_errs(input logic [7:0] t);
      int n = 0;
      for (int i = 0; i < 8; i++)
         if (t[i] != EXP[i]) n++;
      return n;
   endfunction

   function automatic int ref_first(input logic [7:0] t);
      for (int i = 0; i < 8; i++)
         if (t[i] != EXP[i]) return i;
      return 0;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      start_l = 1'b0;
      unit_tbl = EXP;
      tbl_l = EXP;
      #2;
      n_chk++;
      if ({busy, done, pass, err_count, ffi, ffv, vsel} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_state got=%b want=0",
                  {busy, done, pass, err_count, ffi, ffv, vsel});
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic run_sweep(input logic [7:0] tbl, input bit poke,
                            input string name);
      logic [3:0] e_err;
      int         e_first;
      int         vec_bad = 0;
      int         extra_done = 0;
      e_err   = 4'(ref_errs(tbl));
      e_first = ref_first(tbl);
      unit_tbl = tbl;
      start = 1'b1;
      tick();
      start = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_rise got=%b want=1", name, busy);
      end
      for (int i = 0; i < 32; i++) begin
         if (vsel !== 3'(i / 4) || done !== 1'b0 || busy !== 1'b1)
            vec_bad++;
         start = (poke && i == 13);
         tick();
      end
      start = 1'b0;
      n_chk++;
      if (vec_bad != 0) begin
         n_fail++;
         $display("FAIL %s vec_seq bad_cycles=%0d want=0", name, vec_bad);
      end
      n_chk++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done_at_32 got=%b want=1", name, done);
      end
      n_chk++;
      if (err_count !== e_err || pass !== (e_err == 0)) begin
         n_fail++;
         $display("FAIL %s result err=%0d pass=%b want err=%0d pass=%b",
                  name, err_count, pass, e_err, (e_err == 0));
      end
      n_chk++;
      if (ffv !== (e_err != 0) || (e_err != 0 && ffi !== 3'(e_first))) begin
         n_fail++;
         $display("FAIL %s first_fail v=%b idx=%0d want v=%b idx=%0d",
                  name, ffv, ffi, (e_err != 0), e_first);
      end
`ifdef FAIL_MASK_EN
      n_chk++;
      if (fmask !== (tbl ^ EXP)) begin
         n_fail++;
         $display("FAIL %s fail_mask got=%b want=%b", name, fmask, tbl ^ EXP);
      end
`endif
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done !== 1'b0 || busy !== 1'b0) extra_done++;
      end
      n_chk++;
      if (extra_done != 0) begin
         n_fail++;
         $display("FAIL %s idle_after bad_cycles=%0d want=0", name, extra_done);
      end
   endtask

   task automatic test_sweeps();
      logic [7:0] t;
      run_sweep(8'h40, 1'b0, "correct");
      run_sweep(8'h00, 1'b0, "tied0");
      run_sweep(8'hFF, 1'b0, "tied1");
      for (int k = 0; k < 4; k++) begin
         t = 8'($urandom);
         run_sweep(t, 1'b0, "random");
      end
   endtask

   task automatic test_start_ignored();
      run_sweep(8'h40, 1'b1, "start_busy");
      run_sweep(8'h05, 1'b1, "start_busy_err");
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      unit_tbl = 8'h40;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      n_chk++;
      if (vsel !== 3'd4 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_pre vec=%0d busy=%b want vec=4 busy=1", vsel, busy);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, done, pass, err_count, ffi, ffv, vsel} !== 15'd0) begin
         n_fail++;
         $display("FAIL mid_async got=%b want=0",
                  {busy, done, pass, err_count, ffi, ffv, vsel});
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i == 3) rst_n = 1'b1;
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL mid_no_done bad_cycles=%0d want=0", bad);
      end
      run_sweep(8'h40, 1'b0, "after_reset");
   endtask

   task automatic test_loop();
      int dones[$];
      int bad_busy = 0;
      int bad_res  = 0;
      tbl_l = 8'h41;
      start_l = 1'b1;
      tick();
      start_l = 1'b0;
      for (int t = 0; t < 110; t++) begin
         if (busy_l !== 1'b1) bad_busy++;
         if (done_l === 1'b1) begin
            dones.push_back(t);
            if (dones.size() == 1) begin
               if (err_l !== 4'd1 || pass_l !== 1'b0 || ffi_l !== 3'd0 ||
                   ffv_l !== 1'b1) bad_res++;
               tbl_l = 8'h40;
            end else if (err_l !== 4'd0 || pass_l !== 1'b1) begin
               bad_res++;
            end
         end
         tick();
      end
      n_chk++;
      if (dones.size() != 3 || dones[0] != 32 || dones[1] != 65 ||
          dones[2] != 98) begin
         n_fail++;
         $display("FAIL loop_period count=%0d want 3 pulses at 32/65/98",
                  dones.size());
      end
      n_chk++;
      if (bad_busy != 0) begin
         n_fail++;
         $display("FAIL loop_busy low_cycles=%0d want=0", bad_busy);
      end
      n_chk++;
      if (bad_res != 0) begin
         n_fail++;
         $display("FAIL loop_results bad=%0d want=0", bad_res);
      end
   endtask

   initial begin
      test_reset();
      test_sweeps();
      test_start_ignored();
      test_reset_mid();
      test_loop();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vec_sweep_checker.md
Name: vec_sweep_checker

Overview:
Synthesizable sweep-and-check stage for 3-input/1-output combinational units.
- Upstream side: drives every input vector {a,b,c} = 000..111 in order.
- Waits a settle interval per vector, then samples the unit's output d.
- Downstream side: compares d against a parameterised truth table and reports pass/fail, mismatch count and first failing vector.
- Replaces free-running simulation stimulus so the check can run in hardware.

Parameters:
SETTLE, 3, cycles each vector is held before d is sampled; legal range 1..15.
EXPECTED, 8'b0100_0000, bit i = required d for vector i = {a,b,c}; default is d=1 only for a=1,b=1,c=0.
LOOP, 0, 0 = one sweep per start; 1 = restart automatically after every sweep.

Ports:
clk  in  1  single system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request a sweep; sampled only in IDLE
a  out  1  vector bit 2 to unit under check
b  out  1  vector bit 1
c  out  1  vector bit 0
d  in  1  unit output; must be stable by the sample cycle
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse at end of sweep
pass  out  1  1 when the last completed sweep had zero mismatches
err_count  out  4  mismatches in the last/current sweep, range 0..8
first_fail_idx  out  3  index of the first mismatching vector
first_fail_valid  out  1  first_fail_idx is meaningful

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, {a,b,c}=000, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_valid=0, wait counter=0.
- Reset asserted mid-sweep aborts immediately and forces all reset values; no done pulse is generated.
- All outputs are registered.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1: vec<=0, err_count<=0, first_fail_valid<=0, wait_cnt<=SETTLE, busy<=1, go to WAIT.
  - start=0: stay; outputs hold their last values.
- WAIT: wait_cnt decrements each cycle. When wait_cnt==1, go to SAMPLE.
- SAMPLE: compare d with EXPECTED[vec].
  - On mismatch: err_count+1; if first_fail_valid==0, latch first_fail_idx<=vec and set first_fail_valid.
  - If vec==7, go to DONE.
  - Otherwise vec<=vec+1, wait_cnt<=SETTLE, go to WAIT.
- DONE: done=1 for exactly this cycle; pass<=(final err_count==0), including a mismatch found on vector 7.
  - LOOP=0: busy<=0, go to IDLE.
  - LOOP=1: behave as an accepted start (counters cleared, vec=0, busy stays 1).
- Timing: each vector is held for SETTLE+1 cycles; {a,b,c} changes only on SAMPLE-to-WAIT transitions. Done rises 8*(SETTLE+1) cycles after busy rises (32 for SETTLE=3).
- start while busy is ignored; no queuing.
- err_count cannot exceed 8, so no overflow.
- pass and first_fail_* hold until the next sweep clears them.

Optional Feature:
FAIL_MASK_EN
- Defined: adds output fail_mask[7:0]. Bit i is set when vector i mismatched in the current sweep; cleared on sweep start; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Unit model d=a&b&~c, SETTLE=3, pulse start -> vectors 000..111 each held 4 cycles; done 32 cycles after busy rises; pass=1, err_count=0, first_fail_valid=0.
- d tied 0 -> err_count=1, first_fail_idx=6, first_fail_valid=1, pass=0.
- d tied 1 -> err_count=7, first_fail_idx=0, pass=0. With FAIL_MASK_EN: fail_mask=8'b1011_1111.
- Start pulsed again at vector 3 of a running sweep -> ignored; single done at cycle 32; results match an undisturbed sweep.
- rst_n low while vec=4 -> all outputs reset asynchronously with no done; a new start gives a clean full sweep with pass=1.
- LOOP=1, correct unit -> done pulses every 33 cycles; busy stays 1; err_count cleared each sweep; pass=1 after each.
